// File: rtl/fp_subtractor_seq.sv
// Multi-cycle single-precision subtractor: result = op_a - op_b.
// One-bit-per-cycle alignment and normalisation, truncating, flush-to-zero.
module fp_subtractor_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     op_a,
  input  logic [EXP_W+MAN_W:0]     op_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [2:0]               flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;
  localparam int SW = MAN_W + 2;

  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] EONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] FAR  = EXP_W'(MAN_W + 1);

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_INV  = 3'b100;
  localparam logic [2:0] F_OVF  = 3'b010;
  localparam logic [2:0] F_UNF  = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  state_t state;

  logic             sign_l;
  logic             sign_s;
  logic [EXP_W-1:0] exp_l;
  logic [MW-1:0]    man_l;
  logic [MW-1:0]    man_s;
  logic [EXP_W-1:0] cnt;
  logic [SW-1:0]    sum;

  logic             sa;
  logic             sb;
  logic [EXP_W-1:0] ea;
  logic [EXP_W-1:0] eb;
  logic [MW-1:0]    ma;
  logic [MW-1:0]    mb;
  logic             nan_in;
  logic             b_big;
  logic [EXP_W-1:0] diff;
  logic             far;

  // Operand decode: op_b sign is inverted so the core only ever adds.
  always_comb begin
    sa     = op_a[W-1];
    sb     = ~op_b[W-1];
    ea     = op_a[W-2:MAN_W];
    eb     = op_b[W-2:MAN_W];
    ma     = '0;
    mb     = '0;
    if (|ea) ma = {1'b1, op_a[MAN_W-1:0]};
    if (|eb) mb = {1'b1, op_b[MAN_W-1:0]};
    nan_in = (&ea) | (&eb);
    b_big  = {eb, mb} > {ea, ma};
    diff   = b_big ? (eb - ea) : (ea - eb);
    far    = diff >= FAR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= F_NONE;
      sign_l    <= 1'b0;
      sign_s    <= 1'b0;
      exp_l     <= '0;
      man_l     <= '0;
      man_s     <= '0;
      cnt       <= '0;
      sum       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (nan_in) begin
              result    <= QNAN;
              flags     <= F_INV;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              sign_l <= b_big ? sb : sa;
              sign_s <= b_big ? sa : sb;
              exp_l  <= b_big ? eb : ea;
              man_l  <= b_big ? mb : ma;
              man_s  <= far ? '0 : (b_big ? ma : mb);
              cnt    <= far ? '0 : diff;
              state  <= ALIGN;
            end
          end
        end

        ALIGN: begin
          if (cnt == '0) begin
            state <= ADD;
          end else begin
            man_s <= man_s >> 1;
            cnt   <= cnt - EONE;
          end
        end

        ADD: begin
          if (sign_l == sign_s)
            sum <= {1'b0, man_l} + {1'b0, man_s};
          else
            sum <= {1'b0, man_l} - {1'b0, man_s};
          state <= NORM;
        end

        NORM: begin
          if (sum == '0) begin
            result    <= '0;
            flags     <= F_NONE;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (sum[MAN_W+1]) begin
            sum <= sum >> 1;
            if (exp_l == EMAX - EONE) begin
              result    <= {sign_l, EMAX, {MAN_W{1'b0}}};
              flags     <= F_OVF;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              exp_l <= exp_l + EONE;
            end
          end else if (sum[MAN_W]) begin
            result    <= {sign_l, exp_l, sum[MAN_W-1:0]};
            flags     <= F_NONE;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sum <= sum << 1;
            // Leaving the normal range flushes to a signed zero.
            if (exp_l == EONE) begin
              result    <= {sign_l, {(W-1){1'b0}}};
              flags     <= F_UNF;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              exp_l <= exp_l - EONE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Scoreboard bench for fp_subtractor_seq: directed vectors, queued
// expectations, monitor compares result, flags and latency on out_valid.
module tb_fp_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [2:0]  flags;

  fp_subtractor_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  bit   seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: one comparison set per result presented.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid && !seen) begin
      seen = 1'b1;
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got 0x%08h, expected none",
                 result);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_flags"}, 32'(flags), 32'(e.flg));
        chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end else if (!out_valid) begin
      seen = 1'b0;
    end
  end

  task automatic send(input string nm, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r,
                      input logic [2:0] f, input int lat);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk({nm, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    e.name = nm;
    e.res = r;
    e.flg = f;
    e.lat = lat;
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bit vs;
    int t;

    repeat (2) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'h0);
    chk("reset_flags", 32'(flags), 32'd0);
    rst = 1'b0;

    send("sub3m1",   32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 4);
    send("sub1m1",   32'h3F800000, 32'h3F800000, 32'h00000000, 3'b000, 3);
    send("carry",    32'h3F800000, 32'hBF800000, 32'h40000000, 3'b000, 4);
    send("swap",     32'h3F800000, 32'h40400000, 32'hC0000000, 3'b000, 4);
    send("lshift2",  32'h3FC00000, 32'h3FA00000, 32'h3E800000, 3'b000, 5);
    send("far30",    32'h3F800000, 32'h30800000, 32'h3F800000, 3'b000, 3);
    send("far24",    32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000, 3);
    send("diff23",   32'h3F800000, 32'h34000000, 32'h3F7FFFFE, 3'b000, 27);
    send("inf_a",    32'h7F800000, 32'h3F800000, 32'h7FC00000, 3'b100, 0);
    send("nan_b",    32'h3F800000, 32'h7FC00000, 32'h7FC00000, 3'b100, 0);
    send("ovf",      32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3'b010, 3);
    send("unf",      32'h00800000, 32'h00C00000, 32'h80000000, 3'b001, 3);
    send("denorm",   32'h00400000, 32'h3F800000, 32'hBF800000, 3'b000, 3);
    send("add2p1",   32'h40000000, 32'hBF800000, 32'h40400000, 3'b000, 4);
    send("negneg",   32'hC0400000, 32'hC0000000, 32'hBF800000, 3'b000, 4);
    send("zeros",    32'h80000000, 32'h00000000, 32'h00000000, 3'b000, 3);
    drain();

    // Back-pressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    send("stall", 32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 4);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_result_hold", result, 32'h40000000);
      chk("stall_in_ready_low", 32'(in_ready), 32'd0);
      chk("stall_valid_hold", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Abort during ALIGN: no result may ever appear.
    @(negedge clk);
    op_a = 32'h3F800000;
    op_b = 32'h35800000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    vs = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) vs = 1'b1;
    end
    chk("abort_no_valid", 32'(vs), 32'd0);

    send("recover", 32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 4);
    drain();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
